// File: rtl/max_min_pkg.sv
// Shared sizing helpers and tie policy for the max/min extremum tree.
package max_min_pkg;

   // On equal values the candidate with the lower channel index wins.
   localparam bit TIE_LOW_INDEX = 1'b1;

   // Number of pairwise comparison levels needed to reduce n candidates to one.
   function automatic int tree_levels(input int n);
      int l;
      l = 0;
      while ((1 << l) < n) l++;
      return l;
   endfunction

   // Channel index width; a single channel still carries a 1-bit index.
   function automatic int idx_width(input int n);
      int w;
      w = tree_levels(n);
      return (w < 1) ? 1 : w;
   endfunction

   // Candidates alive at the input of level lvl (level 0 holds all n channels).
   function automatic int level_count(input int n, input int lvl);
      return (n + (1 << lvl) - 1) >> lvl;
   endfunction

endpackage

// File: rtl/max_min_node.sv
// One comparison node: picks the larger of two max candidates and the smaller
// of two min candidates. Purely combinational; the caller owns the registers.
module max_min_node
   import max_min_pkg::*;
#(
   parameter  int WIDTH = 10,
   parameter  int IDX_W = 2,
   localparam int CW    = WIDTH + IDX_W
) (
   input  logic [CW-1:0] lo_max,
   input  logic [CW-1:0] hi_max,
   input  logic [CW-1:0] lo_min,
   input  logic [CW-1:0] hi_min,
   output logic [CW-1:0] win_max,
   output logic [CW-1:0] win_min
);

   // Candidate layout: value in the upper bits, channel index in the lower bits.
   typedef struct packed {
      logic [WIDTH-1:0] value;
      logic [IDX_W-1:0] idx;
   } cand_t;

   cand_t lo_max_c, hi_max_c, lo_min_c, hi_min_c;

   assign lo_max_c = lo_max;
   assign hi_max_c = hi_max;
   assign lo_min_c = lo_min;
   assign hi_min_c = hi_min;

   // True when candidate a should win a tie against candidate b.
   function automatic logic wins_tie(input cand_t a, input cand_t b);
      return TIE_LOW_INDEX ? (a.idx < b.idx) : (a.idx > b.idx);
   endfunction

   // Select winners; lo is kept unless hi is strictly better or wins the tie.
   always_comb begin
      win_max = lo_max;
      win_min = lo_min;
      if ((hi_max_c.value > lo_max_c.value) ||
          ((hi_max_c.value == lo_max_c.value) && wins_tie(hi_max_c, lo_max_c))) begin
         win_max = hi_max;
      end
      if ((hi_min_c.value < lo_min_c.value) ||
          ((hi_min_c.value == lo_min_c.value) && wins_tie(hi_min_c, lo_min_c))) begin
         win_min = hi_min;
      end
   end

endmodule

// File: rtl/max_min_tree.sv
// Streaming N-channel extremum finder: registered pairwise reduction tree for
// max and min with channel indices, followed by an output register that also
// produces range = max - min. The whole pipe stalls as a unit on backpressure.
module max_min_tree
   import max_min_pkg::*;
#(
   parameter  int N      = 3,
   parameter  int WIDTH  = 10,
   parameter  int USER_W = 1,
   localparam int IDX_W  = idx_width(N)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [N*WIDTH-1:0]   in_data,
   input  logic [USER_W-1:0]    in_user,
   input  logic                 in_valid,
   output logic                 in_ready,
   output logic [WIDTH-1:0]     out_max,
   output logic [IDX_W-1:0]     out_max_idx,
   output logic [WIDTH-1:0]     out_min,
   output logic [IDX_W-1:0]     out_min_idx,
   output logic [WIDTH-1:0]     out_range,
   output logic [USER_W-1:0]    out_user,
   output logic                 out_valid,
   input  logic                 out_ready
);

   localparam int LEVELS = tree_levels(N);
   localparam int HALF   = (N + 1) / 2;

   typedef struct packed {
      logic [WIDTH-1:0] value;
      logic [IDX_W-1:0] idx;
   } cand_t;

   // Range never underflows because the max winner is never below the min winner.
   function automatic logic [WIDTH-1:0] range_of(input cand_t mx, input cand_t mn);
      return mx.value - mn.value;
   endfunction

   logic              en;
   cand_t             in_cand [N];
   cand_t             fin_max, fin_min;
   logic              fin_vld;
   logic [USER_W-1:0] fin_user;

   logic              out_valid_d,   out_valid_q;
   logic [WIDTH-1:0]  out_max_d,     out_max_q;
   logic [IDX_W-1:0]  out_max_idx_d, out_max_idx_q;
   logic [WIDTH-1:0]  out_min_d,     out_min_q;
   logic [IDX_W-1:0]  out_min_idx_d, out_min_idx_q;
   logic [WIDTH-1:0]  out_range_d,   out_range_q;
   logic [USER_W-1:0] out_user_d,    out_user_q;

   // Global advance: the pipe moves whenever the output slot is empty or draining.
   always_comb begin
      en       = !out_valid_q || out_ready;
      in_ready = en;
   end

   // Level 0: every channel is both a max and a min candidate carrying its own index.
   always_comb begin
      for (int k = 0; k < N; k++) begin
         in_cand[k].value = in_data[k*WIDTH +: WIDTH];
         in_cand[k].idx   = IDX_W'(k);
      end
   end

   if (LEVELS == 0) begin : g_flat

      // A single channel needs no comparisons; it feeds the output register directly.
      always_comb begin
         fin_max  = in_cand[0];
         fin_min  = in_cand[0];
         fin_vld  = in_valid;
         fin_user = in_user;
      end

   end else begin : g_tree

      cand_t             src_max   [LEVELS][N];
      cand_t             src_min   [LEVELS][N];
      cand_t             node_max  [LEVELS][HALF];
      cand_t             node_min  [LEVELS][HALF];
      cand_t             lvl_max_d [LEVELS][HALF];
      cand_t             lvl_max_q [LEVELS][HALF];
      cand_t             lvl_min_d [LEVELS][HALF];
      cand_t             lvl_min_q [LEVELS][HALF];
      logic [LEVELS-1:0] vld_d, vld_q;
      logic [USER_W-1:0] user_d [LEVELS];
      logic [USER_W-1:0] user_q [LEVELS];

      // Inputs to each level: the raw channels for level 0, the previous level's registers after.
      always_comb begin
         for (int j = 0; j < LEVELS; j++) begin
            for (int k = 0; k < N; k++) begin
               src_max[j][k] = '0;
               src_min[j][k] = '0;
            end
         end
         for (int k = 0; k < N; k++) begin
            src_max[0][k] = in_cand[k];
            src_min[0][k] = in_cand[k];
         end
         for (int j = 1; j < LEVELS; j++) begin
            for (int i = 0; i < HALF; i++) begin
               src_max[j][i] = lvl_max_q[j-1][i];
               src_min[j][i] = lvl_min_q[j-1][i];
            end
         end
      end

      for (genvar j = 0; j < LEVELS; j++) begin : g_lvl
         for (genvar i = 0; i < HALF; i++) begin : g_pair
            if (2*i + 1 < level_count(N, j)) begin : g_node
               max_min_node #(
                  .WIDTH (WIDTH),
                  .IDX_W (IDX_W)
               ) u_node (
                  .lo_max  (src_max[j][2*i]),
                  .hi_max  (src_max[j][2*i+1]),
                  .lo_min  (src_min[j][2*i]),
                  .hi_min  (src_min[j][2*i+1]),
                  .win_max (node_max[j][i]),
                  .win_min (node_min[j][i])
               );
            end else begin : g_none
               assign node_max[j][i] = '0;
               assign node_min[j][i] = '0;
            end
         end
      end

      // Next state for every level: pair winners, odd trailing candidate passes through.
      always_comb begin
         lvl_max_d = lvl_max_q;
         lvl_min_d = lvl_min_q;
         vld_d     = vld_q;
         user_d    = user_q;
         if (en) begin
            for (int j = 0; j < LEVELS; j++) begin
               for (int i = 0; i < HALF; i++) begin
                  if (2*i + 1 < level_count(N, j)) begin
                     lvl_max_d[j][i] = node_max[j][i];
                     lvl_min_d[j][i] = node_min[j][i];
                  end else if (2*i < level_count(N, j)) begin
                     lvl_max_d[j][i] = src_max[j][2*i];
                     lvl_min_d[j][i] = src_min[j][2*i];
                  end else begin
                     lvl_max_d[j][i] = '0;
                     lvl_min_d[j][i] = '0;
                  end
               end
            end
            vld_d[0]  = in_valid;
            user_d[0] = in_user;
            for (int j = 1; j < LEVELS; j++) begin
               vld_d[j]  = vld_q[j-1];
               user_d[j] = user_q[j-1];
            end
         end
      end

      // Stage valids are control state and clear on reset, dropping in-flight vectors.
      always_ff @(posedge clk) begin
         if (rst) begin
            vld_q <= '0;
         end else begin
            vld_q <= vld_d;
         end
      end

      // Stage data and tags are qualified by the valids, so they need no reset.
      always_ff @(posedge clk) begin
         lvl_max_q <= lvl_max_d;
         lvl_min_q <= lvl_min_d;
         user_q    <= user_d;
      end

      // The last level holds a single surviving candidate for each of max and min.
      always_comb begin
         fin_max  = lvl_max_q[LEVELS-1][0];
         fin_min  = lvl_min_q[LEVELS-1][0];
         fin_vld  = vld_q[LEVELS-1];
         fin_user = user_q[LEVELS-1];
      end

   end

   // Output stage: load a new result on advance, hold otherwise; bubbles leave data unchanged.
   always_comb begin
      out_valid_d   = out_valid_q;
      out_max_d     = out_max_q;
      out_max_idx_d = out_max_idx_q;
      out_min_d     = out_min_q;
      out_min_idx_d = out_min_idx_q;
      out_range_d   = out_range_q;
      out_user_d    = out_user_q;
      if (en) begin
         out_valid_d = fin_vld;
         if (fin_vld) begin
            out_max_d     = fin_max.value;
            out_max_idx_d = fin_max.idx;
            out_min_d     = fin_min.value;
            out_min_idx_d = fin_min.idx;
            out_range_d   = range_of(fin_max, fin_min);
            out_user_d    = fin_user;
         end
      end
   end

   // Output registers clear fully on reset so no stale result is visible.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid_q   <= 1'b0;
         out_max_q     <= '0;
         out_max_idx_q <= '0;
         out_min_q     <= '0;
         out_min_idx_q <= '0;
         out_range_q   <= '0;
         out_user_q    <= '0;
      end else begin
         out_valid_q   <= out_valid_d;
         out_max_q     <= out_max_d;
         out_max_idx_q <= out_max_idx_d;
         out_min_q     <= out_min_d;
         out_min_idx_q <= out_min_idx_d;
         out_range_q   <= out_range_d;
         out_user_q    <= out_user_d;
      end
   end

   assign out_valid   = out_valid_q;
   assign out_max     = out_max_q;
   assign out_max_idx = out_max_idx_q;
   assign out_min     = out_min_q;
   assign out_min_idx = out_min_idx_q;
   assign out_range   = out_range_q;
   assign out_user    = out_user_q;

endmodule

// File: tb/tb_max_min_tree.sv
// Self-checking bench for max_min_tree: N=3/W=10 main instance plus N=8/W=12
// and N=1/W=10 instances, compared against a plain-arithmetic reference model.
`timescale 1ns/1ps
module tb_max_min_tree;

   typedef struct packed {
      int mx;
      int mxi;
      int mn;
      int mni;
      int rng;
      int user;
   } res_t;

   int checks = 0;
   int errors = 0;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   // Main instance: N=3, WIDTH=10, USER_W=4
   logic [29:0] m_in_data;
   logic [3:0]  m_in_user;
   logic        m_in_valid, m_in_ready;
   logic [9:0]  m_out_max, m_out_min, m_out_range;
   logic [1:0]  m_out_max_idx, m_out_min_idx;
   logic [3:0]  m_out_user;
   logic        m_out_valid, m_out_ready;

   // N=8, WIDTH=12, USER_W=1
   logic [95:0] e_in_data;
   logic [0:0]  e_in_user;
   logic        e_in_valid, e_in_ready;
   logic [11:0] e_out_max, e_out_min, e_out_range;
   logic [2:0]  e_out_max_idx, e_out_min_idx;
   logic [0:0]  e_out_user;
   logic        e_out_valid, e_out_ready;

   // N=1, WIDTH=10, USER_W=1
   logic [9:0]  s_in_data;
   logic [0:0]  s_in_user;
   logic        s_in_valid, s_in_ready;
   logic [9:0]  s_out_max, s_out_min, s_out_range;
   logic [0:0]  s_out_max_idx, s_out_min_idx;
   logic [0:0]  s_out_user;
   logic        s_out_valid, s_out_ready;

   max_min_tree #(.N(3), .WIDTH(10), .USER_W(4)) dut (
      .clk(clk), .rst(rst), .in_data(m_in_data), .in_user(m_in_user),
      .in_valid(m_in_valid), .in_ready(m_in_ready), .out_max(m_out_max),
      .out_max_idx(m_out_max_idx), .out_min(m_out_min), .out_min_idx(m_out_min_idx),
      .out_range(m_out_range), .out_user(m_out_user), .out_valid(m_out_valid),
      .out_ready(m_out_ready));

   max_min_tree #(.N(8), .WIDTH(12), .USER_W(1)) dut8 (
      .clk(clk), .rst(rst), .in_data(e_in_data), .in_user(e_in_user),
      .in_valid(e_in_valid), .in_ready(e_in_ready), .out_max(e_out_max),
      .out_max_idx(e_out_max_idx), .out_min(e_out_min), .out_min_idx(e_out_min_idx),
      .out_range(e_out_range), .out_user(e_out_user), .out_valid(e_out_valid),
      .out_ready(e_out_ready));

   max_min_tree #(.N(1), .WIDTH(10), .USER_W(1)) dut1 (
      .clk(clk), .rst(rst), .in_data(s_in_data), .in_user(s_in_user),
      .in_valid(s_in_valid), .in_ready(s_in_ready), .out_max(s_out_max),
      .out_max_idx(s_out_max_idx), .out_min(s_out_min), .out_min_idx(s_out_min_idx),
      .out_range(s_out_range), .out_user(s_out_user), .out_valid(s_out_valid),
      .out_ready(s_out_ready));

   res_t q_main [$];

   // Reference: scan channels in order; strict comparisons keep the lowest index on ties.
   function automatic res_t ref_model(input int n, input int w, input logic [191:0] d, input int user);
      int   v [16];
      res_t r;
      for (int k = 0; k < n; k++) begin
         v[k] = 0;
         for (int b = 0; b < w; b++) v[k] = v[k] | (int'(d[k*w + b]) << b);
      end
      r.mx = v[0]; r.mxi = 0; r.mn = v[0]; r.mni = 0;
      for (int k = 1; k < n; k++) begin
         if (v[k] > r.mx) begin r.mx = v[k]; r.mxi = k; end
         if (v[k] < r.mn) begin r.mn = v[k]; r.mni = k; end
      end
      r.rng  = r.mx - r.mn;
      r.user = user;
      return r;
   endfunction

   function automatic string fmt(input res_t r);
      return $sformatf("max=%0d@%0d min=%0d@%0d range=%0d user=%0d", r.mx, r.mxi, r.mn, r.mni, r.rng, r.user);
   endfunction

   function automatic res_t obs_main();
      res_t r;
      r.mx = int'(m_out_max); r.mxi = int'(m_out_max_idx);
      r.mn = int'(m_out_min); r.mni = int'(m_out_min_idx);
      r.rng = int'(m_out_range); r.user = int'(m_out_user);
      return r;
   endfunction

   function automatic res_t obs_e();
      res_t r;
      r.mx = int'(e_out_max); r.mxi = int'(e_out_max_idx);
      r.mn = int'(e_out_min); r.mni = int'(e_out_min_idx);
      r.rng = int'(e_out_range); r.user = int'(e_out_user);
      return r;
   endfunction

   function automatic res_t obs_s();
      res_t r;
      r.mx = int'(s_out_max); r.mxi = int'(s_out_max_idx);
      r.mn = int'(s_out_min); r.mni = int'(s_out_min_idx);
      r.rng = int'(s_out_range); r.user = int'(s_out_user);
      return r;
   endfunction

   // Samples biased toward extremes and repeats so ties occur often.
   function automatic logic [9:0] rs10();
      case ($urandom_range(0, 4))
         0:       return 10'd0;
         1:       return 10'd1023;
         2:       return 10'd512;
         default: return 10'($urandom_range(0, 1023));
      endcase
   endfunction

   function automatic logic [29:0] rvec();
      return {rs10(), rs10(), rs10()};
   endfunction

   // One main-instance cycle: drive at negedge, report handshakes for the coming edge.
   task automatic cyc(input bit v, input logic [29:0] d, input logic [3:0] u, input bit ordy,
                      output bit acc, output bit fire, output res_t obs);
      @(negedge clk);
      m_in_valid = v; m_in_data = d; m_in_user = u; m_out_ready = ordy;
      #1;
      acc  = v && m_in_ready;
      fire = m_out_valid && ordy;
      obs  = obs_main();
   endtask

   task automatic cyc8(input bit v, input logic [95:0] d, input logic [0:0] u,
                       output bit acc, output bit fire, output res_t obs);
      @(negedge clk);
      e_in_valid = v; e_in_data = d; e_in_user = u;
      #1;
      acc  = v && e_in_ready;
      fire = e_out_valid;
      obs  = obs_e();
   endtask

   task automatic cyc1(input bit v, input logic [9:0] d, input logic [0:0] u,
                       output bit acc, output bit fire, output res_t obs);
      @(negedge clk);
      s_in_valid = v; s_in_data = d; s_in_user = u;
      #1;
      acc  = v && s_in_ready;
      fire = s_out_valid;
      obs  = obs_s();
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      #1;
      checks++;
      if (m_out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", m_out_valid); end
      checks++;
      if ({m_out_max, m_out_max_idx, m_out_min, m_out_min_idx, m_out_range, m_out_user} !== '0) begin
         errors++; $display("FAIL reset_data: got %s want all 0", fmt(obs_main()));
      end
      checks++;
      if (m_in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", m_in_ready); end
      checks++;
      if ({e_out_valid, s_out_valid} !== 2'b00) begin
         errors++; $display("FAIL reset_valid_param: got %b%b want 00", e_out_valid, s_out_valid);
      end
   endtask

   task automatic test_basic();
      bit acc, fire; res_t obs; int lat;
      cyc(1'b1, {10'd300, 10'd700, 10'd100}, 4'h5, 1'b1, acc, fire, obs);
      checks++;
      if (!acc) begin errors++; $display("FAIL basic_accept: got 0 want 1"); end
      lat = 0;
      for (int c = 1; c <= 10 && lat == 0; c++) begin
         cyc(1'b0, '0, '0, 1'b1, acc, fire, obs);
         if (fire) lat = c;
      end
      checks++;
      if (lat != 3) begin errors++; $display("FAIL basic_latency: got %0d want 3", lat); end
      checks++;
      if (obs !== '{mx: 700, mxi: 1, mn: 100, mni: 0, rng: 600, user: 5}) begin
         errors++; $display("FAIL basic_result: got %s want max=700@1 min=100@0 range=600 user=5", fmt(obs));
      end
      cyc(1'b0, '0, '0, 1'b1, acc, fire, obs);
      checks++;
      if (fire) begin errors++; $display("FAIL basic_pulse: out_valid got 1 want 0"); end
   endtask

   task automatic test_ties();
      logic [29:0] tv [2];
      res_t        te [2];
      bit acc, fire; res_t obs;
      tv[0] = {10'd500, 10'd500, 10'd500};
      te[0] = '{mx: 500, mxi: 0, mn: 500, mni: 0, rng: 0, user: 2};
      tv[1] = {10'd900, 10'd900, 10'd10};
      te[1] = '{mx: 900, mxi: 1, mn: 10, mni: 0, rng: 890, user: 3};
      for (int t = 0; t < 2; t++) begin
         cyc(1'b1, tv[t], 4'(t + 2), 1'b1, acc, fire, obs);
         fire = 1'b0;
         for (int c = 0; c < 10 && !fire; c++) cyc(1'b0, '0, '0, 1'b1, acc, fire, obs);
         checks++;
         if (!fire || obs !== te[t]) begin
            errors++; $display("FAIL ties_%0d: got %s (seen=%0b) want %s", t, fmt(obs), fire, fmt(te[t]));
         end
      end
   endtask

   task automatic test_stream();
      bit acc, fire; res_t obs, exp; logic [29:0] d; logic [3:0] u;
      int first_fire, last_fire, nfire;
      first_fire = -1; last_fire = -1; nfire = 0;
      for (int c = 0; c < 18; c++) begin
         d = rvec(); u = 4'($urandom_range(0, 15));
         cyc(c < 10, d, u, 1'b1, acc, fire, obs);
         if (c < 10) begin
            checks++;
            if (!acc) begin errors++; $display("FAIL stream_accept_%0d: got 0 want 1", c); end
         end
         if (fire) begin
            checks++;
            if (q_main.size() == 0) begin
               errors++; $display("FAIL stream_extra: got %s want nothing", fmt(obs));
            end else begin
               exp = q_main.pop_front();
               if (obs !== exp) begin errors++; $display("FAIL stream_data: got %s want %s", fmt(obs), fmt(exp)); end
            end
            if (first_fire < 0) first_fire = c;
            last_fire = c;
            nfire++;
         end
         if (acc) q_main.push_back(ref_model(3, 10, 192'(d), int'(u)));
      end
      checks++;
      if (first_fire != 3 || nfire != 10 || last_fire - first_fire != 9) begin
         errors++; $display("FAIL stream_timing: got first=%0d count=%0d span=%0d want 3 10 9",
                            first_fire, nfire, last_fire - first_fire);
      end
   endtask

   task automatic drain_main(input string tag);
      bit acc, fire; res_t obs, exp;
      for (int c = 0; c < 30; c++) begin
         cyc(1'b0, '0, '0, 1'b1, acc, fire, obs);
         if (fire) begin
            checks++;
            if (q_main.size() == 0) begin
               errors++; $display("FAIL %s_extra: got %s want nothing", tag, fmt(obs));
            end else begin
               exp = q_main.pop_front();
               if (obs !== exp) begin errors++; $display("FAIL %s_data: got %s want %s", tag, fmt(obs), fmt(exp)); end
            end
         end
      end
      checks++;
      if (q_main.size() != 0) begin
         errors++; $display("FAIL %s_lost: got %0d pending want 0", tag, q_main.size());
         q_main.delete();
      end
   endtask

   task automatic test_backpressure();
      bit acc, fire; res_t obs, snap; logic [29:0] d; logic [3:0] u;
      for (int c = 0; c < 3; c++) begin
         d = rvec(); u = 4'($urandom_range(0, 15));
         cyc(1'b1, d, u, 1'b0, acc, fire, obs);
         checks++;
         if (!acc) begin errors++; $display("FAIL bp_fill_%0d: in_ready got 0 want 1", c); end
         if (acc) q_main.push_back(ref_model(3, 10, 192'(d), int'(u)));
      end
      snap = '0;
      for (int h = 0; h < 5; h++) begin
         cyc(1'b1, rvec(), 4'hF, 1'b0, acc, fire, obs);
         if (h == 0) snap = obs;
         checks++;
         if (acc || m_out_valid !== 1'b1 || obs !== snap) begin
            errors++; $display("FAIL bp_hold_%0d: got ready=%b valid=%b %s want ready=0 valid=1 %s",
                               h, m_in_ready, m_out_valid, fmt(obs), fmt(snap));
         end
      end
      drain_main("bp");
   endtask

   task automatic test_random();
      bit acc, fire, v, r; res_t obs, exp; logic [29:0] d; logic [3:0] u;
      for (int c = 0; c < 300; c++) begin
         v = ($urandom_range(0, 9) < 7); r = ($urandom_range(0, 9) < 6);
         d = rvec(); u = 4'($urandom_range(0, 15));
         cyc(v, d, u, r, acc, fire, obs);
         if (fire) begin
            checks++;
            if (q_main.size() == 0) begin
               errors++; $display("FAIL rand_extra: got %s want nothing", fmt(obs));
            end else begin
               exp = q_main.pop_front();
               if (obs !== exp) begin errors++; $display("FAIL rand_data: got %s want %s", fmt(obs), fmt(exp)); end
            end
         end
         if (acc) q_main.push_back(ref_model(3, 10, 192'(d), int'(u)));
      end
      drain_main("rand");
   endtask

   task automatic test_reset_midstream();
      bit acc, fire; res_t obs; int extra;
      for (int c = 0; c < 3; c++) cyc(1'b1, rvec(), 4'hA, 1'b1, acc, fire, obs);
      @(negedge clk);
      rst = 1'b1; m_in_valid = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      #1;
      checks++;
      if (m_out_valid !== 1'b0 ||
          {m_out_max, m_out_max_idx, m_out_min, m_out_min_idx, m_out_range, m_out_user} !== '0) begin
         errors++; $display("FAIL midrst_clear: got valid=%b %s want valid=0 all 0", m_out_valid, fmt(obs_main()));
      end
      q_main.delete();
      extra = 0;
      for (int c = 0; c < 8; c++) begin
         cyc(1'b0, '0, '0, 1'b1, acc, fire, obs);
         if (fire) extra++;
      end
      checks++;
      if (extra != 0) begin errors++; $display("FAIL midrst_stale: got %0d results want 0", extra); end
   endtask

   task automatic test_n8();
      bit acc, fire; res_t obs, exp; logic [95:0] d; logic [0:0] u; int lat; res_t qe [$];
      for (int k = 0; k < 8; k++) d[k*12 +: 12] = 12'($urandom_range(1, 4094));
      d[5*12 +: 12] = 12'd4095;
      d[2*12 +: 12] = 12'd0;
      cyc8(1'b1, d, 1'b1, acc, fire, obs);
      lat = 0;
      for (int c = 1; c <= 10 && lat == 0; c++) begin
         cyc8(1'b0, '0, '0, acc, fire, obs);
         if (fire) lat = c;
      end
      checks++;
      if (lat != 4) begin errors++; $display("FAIL n8_latency: got %0d want 4", lat); end
      checks++;
      if (obs.mx != 4095 || obs.mxi != 5 || obs.mn != 0 || obs.mni != 2 || obs.rng != 4095) begin
         errors++; $display("FAIL n8_extremes: got %s want max=4095@5 min=0@2 range=4095", fmt(obs));
      end
      for (int c = 0; c < 16; c++) begin
         for (int k = 0; k < 8; k++) d[k*12 +: 12] = ($urandom_range(0, 2) == 0) ? 12'd77 : 12'($urandom_range(0, 4095));
         u = 1'($urandom_range(0, 1));
         cyc8(c < 8, d, u, acc, fire, obs);
         if (fire) begin
            checks++;
            exp = (qe.size() > 0) ? qe.pop_front() : '{default: -1};
            if (obs !== exp) begin errors++; $display("FAIL n8_stream: got %s want %s", fmt(obs), fmt(exp)); end
         end
         if (acc) qe.push_back(ref_model(8, 12, 192'(d), int'(u)));
      end
      checks++;
      if (qe.size() != 0) begin errors++; $display("FAIL n8_lost: got %0d pending want 0", qe.size()); end
   endtask

   task automatic test_n1();
      logic [9:0] vals [3];
      bit acc, fire; res_t obs; int lat;
      vals[0] = 10'($urandom_range(1, 1022)); vals[1] = 10'd0; vals[2] = 10'd1023;
      for (int t = 0; t < 3; t++) begin
         cyc1(1'b1, vals[t], 1'(t), acc, fire, obs);
         lat = 0;
         for (int c = 1; c <= 5 && lat == 0; c++) begin
            cyc1(1'b0, '0, '0, acc, fire, obs);
            if (fire) lat = c;
         end
         checks++;
         if (lat != 1 || obs.mx != int'(vals[t]) || obs.mn != int'(vals[t]) || obs.mxi != 0 ||
             obs.mni != 0 || obs.rng != 0 || obs.user != (t & 1)) begin
            errors++; $display("FAIL n1_%0d: got lat=%0d %s want lat=1 max=min=%0d@0 range=0 user=%0d",
                               t, lat, fmt(obs), vals[t], t & 1);
         end
      end
   endtask

   initial begin
      m_in_data = '0; m_in_user = '0; m_in_valid = 1'b0; m_out_ready = 1'b1;
      e_in_data = '0; e_in_user = '0; e_in_valid = 1'b0; e_out_ready = 1'b1;
      s_in_data = '0; s_in_user = '0; s_in_valid = 1'b0; s_out_ready = 1'b1;
      rst = 1'b1;
      test_reset();
      test_basic();
      test_ties();
      test_stream();
      test_backpressure();
      test_random();
      test_reset_midstream();
      test_n8();
      test_n1();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete within 200000 ns");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/max_min_tree.md
Name: max_min_tree

Overview:
- Streaming, pipelined N-channel extremum finder.
- Each accepted input vector of N unsigned samples produces:
  - the maximum value and its channel index,
  - the minimum value and its channel index,
  - the range (max − min).
- Sits in the skin-colour segmentation path between pixel capture and the RGB→HSV stage, which uses max (V), range (S numerator) and max index (hue sector).
- Valid/ready handshake with full backpressure; an opaque user tag travels alongside each vector.

Parameters:
- N, 3: number of input channels, 1..16.
- WIDTH, 10: sample width in bits, unsigned.
- USER_W, 1: width of the pass-through sideband tag (e.g. pixel sync flags), ≥1.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_data  in  N*WIDTH  packed samples; channel k at bits [k*WIDTH +: WIDTH].
- in_user  in  USER_W  sideband tag for the vector.
- in_valid  in  1  input vector present.
- in_ready  out  1  block can accept this cycle.
- out_max  out  WIDTH  largest sample.
- out_max_idx  out  IDX_W  channel of the largest sample; IDX_W = max(1, clog2(N)).
- out_min  out  WIDTH  smallest sample.
- out_min_idx  out  IDX_W  channel of the smallest sample.
- out_range  out  WIDTH  out_max − out_min, never negative.
- out_user  out  USER_W  in_user of the same vector.
- out_valid  out  1  result present.
- out_ready  in  1  consumer accepts result.

Behaviour:
- One clock (clk). Reset is synchronous and active-high (rst).
- Reset values:
  - out_valid = 0.
  - All data, index and user outputs = 0.
  - All internal stage valids = 0.
- Reset mid-operation discards all in-flight vectors; nothing is emitted for them.
- Pipeline: LEVELS = clog2(N) registered comparison levels, then one output register computing range. Latency LAT = LEVELS + 1 cycles (N=3 → 3, N=8 → 4, N=1 → 1).
- Global advance enable: en = !out_valid || out_ready.
  - in_ready = en (combinational from out_valid/out_ready only, never from in_valid).
  - When en = 0, every stage holds its data and valid.
  - Bubbles are not compressed: the whole pipe stalls as a unit.
- Transfers:
  - An input transfer occurs when in_valid && in_ready.
  - Stage valid bits shift on en; a bubble (in_valid = 0 while en = 1) enters as valid = 0.
  - The output holds stable, with out_valid = 1, until out_ready = 1.
- Tree, level 0: each channel k is both max candidate and min candidate, with index k.
- Tree, level j: candidates are paired (2i, 2i+1). An odd trailing candidate passes through unchanged, with its register.
- Tie rule: on equal values the lower channel index wins, for both max and min. Example: all channels equal → max_idx = min_idx = 0.
- Comparisons are unsigned, WIDTH bits.
- Range = max − min in WIDTH bits; it cannot underflow because max ≥ min.
- User tag is delayed exactly LAT stages, aligned with its vector.
- Throughput is one vector per cycle when out_ready is held 1.

Decomposition:
- Shared package max_min_pkg holds:
  - function idx_width(n),
  - function tree_levels(n),
  - localparam tie policy constant TIE_LOW_INDEX = 1,
  - struct cand_t {value[WIDTH], idx[IDX_W]}, with the package parametrised via per-module localparams.
- Sub-module max_min_node: purely combinational. Takes two max candidates and two min candidates and returns the winners with the tie rule applied. It is instantiated per pair per level; registers live in max_min_tree.

Test Plan:
- N=3, W=10, in_data = {c=300, b=700, a=100}, out_ready=1 → after 3 cycles: max=700, max_idx=1, min=100, min_idx=0, range=600, out_valid pulses for 1 cycle.
- Ties: {c=500, b=500, a=500} → max_idx=0, min_idx=0, range=0. {c=900, b=900, a=10} → max_idx=1, min_idx=0.
- Streaming: 10 back-to-back random vectors, out_ready=1 → 10 results on consecutive cycles, first at cycle 3, order and user tags preserved, matching a scoreboard model.
- Backpressure: hold out_ready=0 for 5 cycles with the pipe full → in_ready=0, outputs stable. Release → no loss or duplication; results match the scoreboard.
- Reset mid-stream: assert rst for 1 cycle with 3 vectors in flight → next cycle out_valid=0, outputs 0, no stale results emitted afterward.
- Parameter sweep, with N=8 and W=12:
  - {0..7 → 4095 at ch5, 0 at ch2} → max=4095, idx=5; min=0, idx=2; latency 4.
  - N=1 → max=min=input, idx=0, range=0, latency 1.
